pipeline_hazard_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage ARM core: drives freeze/flush of PC, IF/ID and ID/EX regs.

---
 rtl/arm_pipe_pkg.sv | 23 ++
 rtl/hazard_detect.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM core pipeline control: FSM encodings,
// the stage-register control bundle and small helpers.
package arm_pipe_pkg;

  localparam int ARM_REG_W = 4;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_BR_FLUSH = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  typedef struct packed {
    logic freeze_pc;
    logic freeze_if_id;
    logic flush_if_id;
    logic flush_id_ex;
    logic stall_all;
  } pipe_ctl_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// RAW hazard compare between the ID-stage sources and the EX/MEM destinations.
// With forwarding active only a load-use against EX can still cause a hazard.
module hazard_detect
  import arm_pipe_pkg::*;
#(
  parameter int REG_W = ARM_REG_W
) (
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             fwd_en,
  output logic             haz
);

  logic ex_m1, ex_m2, mem_m1, mem_m2;

  always_comb begin
    ex_m1  = id_use_src1 & ex_wb_en  & (id_src1 == ex_dest);
    ex_m2  = id_use_src2 & ex_wb_en  & (id_src2 == ex_dest);
    mem_m1 = id_use_src1 & mem_wb_en & (id_src1 == mem_dest);
    mem_m2 = id_use_src2 & mem_wb_en & (id_src2 == mem_dest);
    // Forwarded values cover every case except a load still in EX.
    if (fwd_en) haz = ex_mem_read & (ex_m1 | ex_m2);
    else        haz = ex_m1 | ex_m2 | mem_m1 | mem_m2;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline sequencer: memory-wait stall > taken-branch flush > RAW hazard
// bubble. Controls are combinational from state and inputs; state/counters registered.
module pipeline_hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int REG_W        = ARM_REG_W,
  parameter int BR_FLUSH_CYC = 1,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             fwd_en,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             stall_all,
  output logic             mem_timeout,
  output logic [15:0]      stall_cycles
);

  localparam int BR_W   = $clog2(BR_FLUSH_CYC) + 1;
  localparam int WAIT_W = ($clog2(MEM_WAIT_MAX + 1) < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [BR_W-1:0]   BR_RELOAD  = BR_W'(BR_FLUSH_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

  logic [1:0]        state_q, state_d;
  logic [BR_W-1:0]   br_left_q, br_left_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [15:0]       stall_cycles_q, stall_cycles_d;
  logic              haz;
  logic              mem_stall;
  pipe_ctl_t         ctl;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_use_src1 (id_use_src1),
    .id_use_src2 (id_use_src2),
    .ex_dest     (ex_dest),
    .ex_wb_en    (ex_wb_en),
    .ex_mem_read (ex_mem_read),
    .mem_dest    (mem_dest),
    .mem_wb_en   (mem_wb_en),
    .fwd_en      (fwd_en),
    .haz         (haz)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d       = state_q;
    br_left_d     = br_left_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    ctl           = '0;

    // Once waiting, only mem_ready matters; the request may already have dropped.
    mem_stall = (state_q == ST_MEM_WAIT) ? !mem_ready : (mem_req & !mem_ready);

    if (mem_stall) begin
      ctl.stall_all    = 1'b1;
      ctl.freeze_pc    = 1'b1;
      ctl.freeze_if_id = 1'b1;
      state_d          = ST_MEM_WAIT;
      if (state_q != ST_MEM_WAIT)     wait_cnt_d = WAIT_W'(1);
      else if (wait_cnt_q != WAIT_LIMIT) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      if (wait_cnt_d == WAIT_LIMIT) mem_timeout_d = 1'b1;
    end else if (state_q == ST_BR_FLUSH) begin
      // Wrong-path slots: new branches and hazards are both irrelevant here.
      ctl.flush_if_id = 1'b1;
      ctl.flush_id_ex = 1'b1;
      if (br_left_q <= BR_W'(1)) state_d = ST_RUN;
      else                       br_left_d = br_left_q - BR_W'(1);
    end else if (br_taken) begin
      ctl.flush_if_id = 1'b1;
      ctl.flush_id_ex = 1'b1;
      if (BR_FLUSH_CYC > 1) begin
        state_d   = ST_BR_FLUSH;
        br_left_d = BR_RELOAD;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      state_d = ST_RUN;
      if (haz) begin
        ctl.freeze_pc    = 1'b1;
        ctl.freeze_if_id = 1'b1;
        ctl.flush_id_ex  = 1'b1;
      end
    end

    stall_cycles_d = ctl.freeze_pc ? sat_inc16(stall_cycles_q) : stall_cycles_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: only control state is reset; datapath-free, so every flop here needs a known value.
      state_q        <= ST_RUN;
      br_left_q      <= '0;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops sample the same pre-edge values.
      state_q        <= state_d;
      br_left_q      <= br_left_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Combinational controls are forced low for the whole time reset is held.
  assign freeze_pc    = rst & ctl.freeze_pc;
  assign freeze_if_id = rst & ctl.freeze_if_id;
  assign flush_if_id  = rst & ctl.flush_if_id;
  assign flush_id_ex  = rst & ctl.flush_id_ex;
  assign stall_all    = rst & ctl.stall_all;
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a hazard vector table followed by
// hand-written branch, memory-wait, timeout and mid-wait reset sequences.
module tb_pipeline_hazard_ctrl;

  localparam logic [4:0] P_IDLE = 5'b00000;
  localparam logic [4:0] P_HAZ  = 5'b11010;
  localparam logic [4:0] P_BR   = 5'b00110;
  localparam logic [4:0] P_MEM  = 5'b11001;

  typedef struct {
    string      nm;
    logic       fwd, u1, u2, exwb, exld, memwb, mreq, mrdy, exp_haz;
    logic [3:0] s1, s2, exd, memd;
  } vec_t;

  logic        clk, rst;
  logic [3:0]  id_src1, id_src2, ex_dest, mem_dest;
  logic        id_use_src1, id_use_src2, ex_wb_en, ex_mem_read, mem_wb_en;
  logic        fwd_en, br_taken, mem_req, mem_ready;
  logic        freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, stall_all, mem_timeout;
  logic [15:0] stall_cycles;
  logic [4:0]  ctl_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_sc   = 0;
  vec_t vecs[$];

  pipeline_hazard_ctrl #(.REG_W(4), .BR_FLUSH_CYC(2), .MEM_WAIT_MAX(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_use_src1  (id_use_src1),
    .id_use_src2  (id_use_src2),
    .ex_dest      (ex_dest),
    .ex_wb_en     (ex_wb_en),
    .ex_mem_read  (ex_mem_read),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .fwd_en       (fwd_en),
    .br_taken     (br_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .freeze_pc    (freeze_pc),
    .freeze_if_id (freeze_if_id),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .stall_all    (stall_all),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles)
  );

  assign ctl_o = {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, stall_all};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input string nm, input logic fwd,
                         input logic u1, input logic [3:0] s1, input logic u2, input logic [3:0] s2,
                         input logic [3:0] exd, input logic exwb, input logic exld,
                         input logic [3:0] memd, input logic memwb,
                         input logic mreq, input logic mrdy, input logic exp_haz);
    vec_t v;
    v.nm = nm; v.fwd = fwd; v.u1 = u1; v.s1 = s1; v.u2 = u2; v.s2 = s2;
    v.exd = exd; v.exwb = exwb; v.exld = exld; v.memd = memd; v.memwb = memwb;
    v.mreq = mreq; v.mrdy = mrdy; v.exp_haz = exp_haz;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    fwd_en = v.fwd; id_use_src1 = v.u1; id_src1 = v.s1; id_use_src2 = v.u2; id_src2 = v.s2;
    ex_dest = v.exd; ex_wb_en = v.exwb; ex_mem_read = v.exld;
    mem_dest = v.memd; mem_wb_en = v.memwb; mem_req = v.mreq; mem_ready = v.mrdy;
  endtask

  task automatic clear_inputs();
    id_src1 = '0; id_src2 = '0; id_use_src1 = 0; id_use_src2 = 0;
    ex_dest = '0; ex_wb_en = 0; ex_mem_read = 0; mem_dest = '0; mem_wb_en = 0;
    fwd_en = 0; br_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  // EX-stage producer of r3 read as src1 with forwarding off.
  task automatic set_ex_hazard();
    fwd_en = 0; id_use_src1 = 1; id_src1 = 4'd3; ex_dest = 4'd3; ex_wb_en = 1;
  endtask

  initial begin
    //        name              fwd u1 s1  u2 s2   exd exwb exld memd memwb mreq mrdy haz
    add_vec("fwd0_ex_s1",       0,  1, 3,  0, 0,   3,  1,   0,   0,   0,    0,   0,   1);
    add_vec("fwd1_ex_noload",   1,  1, 3,  0, 0,   3,  1,   0,   0,   0,    0,   0,   0);
    add_vec("fwd1_loaduse",     1,  1, 3,  0, 0,   3,  1,   1,   0,   0,    0,   0,   1);
    add_vec("fwd0_mem_s2",      0,  0, 0,  1, 5,   9,  1,   0,   5,   1,    0,   0,   1);
    add_vec("fwd1_mem_only",    1,  0, 0,  1, 5,   9,  1,   1,   5,   1,    0,   0,   0);
    add_vec("fwd0_nouse",       0,  0, 3,  0, 3,   3,  1,   0,   3,   1,    0,   0,   0);
    add_vec("fwd0_nowb",        0,  1, 3,  1, 4,   3,  0,   0,   4,   0,    0,   0,   0);
    add_vec("fwd0_r15",         0,  0, 0,  1, 15,  15, 1,   0,   0,   0,    0,   0,   1);
    add_vec("fwd0_nearmiss",    0,  1, 7,  1, 8,   6,  1,   0,   9,   1,    0,   0,   0);
    add_vec("fwd1_load_s2",     1,  1, 2,  1, 12,  12, 1,   1,   0,   0,    0,   0,   1);
    add_vec("fwd1_load_nowb",   1,  1, 2,  0, 0,   2,  0,   1,   0,   0,    0,   0,   0);
    add_vec("memreq_ready",     0,  0, 0,  0, 0,   0,  0,   0,   0,   0,    1,   1,   0);
    add_vec("memreq_ready_haz", 0,  1, 4,  0, 0,   4,  1,   0,   0,   0,    1,   1,   1);
    add_vec("idle",             0,  0, 0,  0, 0,   0,  0,   0,   0,   0,    0,   0,   0);

    // Reset: hazard inputs present but every output must stay low.
    rst = 1'b0;
    clear_inputs();
    set_ex_hazard();
    #3;
    check("reset_ctl", 32'(ctl_o), 32'(P_IDLE));
    check("reset_stall_cycles", 32'(stall_cycles), 32'd0);
    check("reset_timeout", 32'(mem_timeout), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();

    // Table of single-cycle hazard vectors, all evaluated in RUN.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      check({vecs[i].nm, "_sc_before"}, 32'(stall_cycles), 32'(exp_sc));
      drive(vecs[i]);
      #1;
      check(vecs[i].nm, 32'(ctl_o), vecs[i].exp_haz ? 32'(P_HAZ) : 32'(P_IDLE));
      if (vecs[i].exp_haz) exp_sc++;
    end

    // Branch with a concurrent hazard: two flush cycles, no freeze, br_taken ignored in BR_FLUSH.
    @(negedge clk);
    check("pre_branch_sc", 32'(stall_cycles), 32'(exp_sc));
    clear_inputs();
    set_ex_hazard();
    br_taken = 1;
    #1 check("br_cycle1", 32'(ctl_o), 32'(P_BR));
    @(negedge clk);
    #1 check("br_cycle2_ignored", 32'(ctl_o), 32'(P_BR));
    @(negedge clk);
    br_taken = 0;
    #1 check("br_done_hazard", 32'(ctl_o), 32'(P_HAZ));
    exp_sc++;
    @(negedge clk);
    clear_inputs();
    #1 check("br_idle", 32'(ctl_o), 32'(P_IDLE));
    check("br_sc", 32'(stall_cycles), 32'(exp_sc));

    // Four-cycle memory wait with a deferred branch released on mem_ready.
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      mem_req = 1; mem_ready = 0; br_taken = 1;
      #1 check($sformatf("memwait_cyc%0d", k), 32'(ctl_o), 32'(P_MEM));
    end
    exp_sc += 4;
    @(negedge clk);
    mem_ready = 1;
    #1 check("memwait_release_branch", 32'(ctl_o), 32'(P_BR));
    @(negedge clk);
    clear_inputs();
    #1 check("memwait_brflush2", 32'(ctl_o), 32'(P_BR));
    @(negedge clk);
    #1 check("memwait_idle", 32'(ctl_o), 32'(P_IDLE));
    check("memwait_sc", 32'(stall_cycles), 32'(exp_sc));
    check("memwait_no_timeout", 32'(mem_timeout), 32'd0);

    // Sixteen-cycle wait: timeout is registered at the end of stall cycle 15.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      mem_req = 1; mem_ready = 0;
      #1;
      check($sformatf("to_ctl_cyc%0d", k), 32'(ctl_o), 32'(P_MEM));
      check($sformatf("to_flag_cyc%0d", k), 32'(mem_timeout), (k >= 16) ? 32'd1 : 32'd0);
    end
    exp_sc += 16;
    @(negedge clk);
    mem_ready = 1;
    #1 check("to_release", 32'(ctl_o), 32'(P_IDLE));
    @(negedge clk);
    clear_inputs();
    #1 check("to_sticky", 32'(mem_timeout), 32'd1);
    check("to_sc", 32'(stall_cycles), 32'(exp_sc));

    // Asynchronous reset in the middle of a memory wait.
    @(negedge clk);
    mem_req = 1; mem_ready = 0;
    @(negedge clk);
    #1 check("rstwait_stalling", 32'(ctl_o), 32'(P_MEM));
    #2 rst = 1'b0;
    #1;
    check("rstwait_ctl", 32'(ctl_o), 32'(P_IDLE));
    check("rstwait_sc", 32'(stall_cycles), 32'd0);
    check("rstwait_timeout", 32'(mem_timeout), 32'd0);
    exp_sc = 0;
    @(posedge clk);
    #1 check("rstwait_held_ctl", 32'(ctl_o), 32'(P_IDLE));
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    #1 check("post_rst_run", 32'(ctl_o), 32'(P_IDLE));
    @(negedge clk);
    check("post_rst_sc", 32'(stall_cycles), 32'd0);
    set_ex_hazard();
    #1 check("post_rst_hazard", 32'(ctl_o), 32'(P_HAZ));
    exp_sc++;
    @(negedge clk);
    clear_inputs();
    check("post_rst_sc_inc", 32'(stall_cycles), 32'(exp_sc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
